aes_block_collect: RTL

- Downstream of the AES chip top. Consumes the byte stream on chip_data, qualified per byte by the sho strobe.
- Reassembles 16 consecutive bytes into one 128-bit result block and presents it to a host-side consumer over a valid/ready handshake.
- Discards stale partial blocks on an idle timeout and flags lost bytes.

---
 rtl/aes_pkg.sv | 25 ++
 rtl/aes_idle_timer.sv | 42 ++++
 rtl/aes_block_collect.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES result-collection path: FSM state
// encoding, block geometry and a byte-lane write helper.
package aes_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_e;

   localparam int AES_BLOCK_BYTES = 16;
   localparam int AES_BLOCK_W     = 128;

   // Replace byte lane 'lane' of a block; lane 0 occupies the top byte [127:120].
   function automatic logic [AES_BLOCK_W-1:0] lane_write(
      input logic [AES_BLOCK_W-1:0] blk,
      input logic [3:0]             lane,
      input logic [7:0]             b
   );
      logic [AES_BLOCK_W-1:0] r;
      r = blk;
      r[AES_BLOCK_W-1-8*lane -: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/aes_idle_timer.sv
// Idle counter: counts enabled idle cycles, clears on request and emits a
// single expire pulse on the cycle the count would reach TIMEOUT_CYCLES.
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module aes_idle_timer #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 11
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);

   localparam bit             ENABLED = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(ENABLED ? TIMEOUT_CYCLES - 1 : 0);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Expire on the idle cycle that completes the allowed window.
   assign expire_o = ENABLED && inc_i && (cnt_q == LAST);

   // Next count: clear wins, expiry restarts the window, otherwise count idle cycles.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || expire_o) begin
         cnt_d = '0;
      end else if (ENABLED && inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/aes_block_collect.sv
// Collects the AES byte stream into 128-bit blocks and offers each block to
// a host consumer over valid/ready. Partial blocks idle for TIMEOUT_CYCLES
// are discarded. Optional checksum: define AES_COLLECT_CHECKSUM_EN to drive
// block_xor with the XOR of the held block's 16 bytes (else tied to 0).
module aes_block_collect
   import aes_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 11
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   input  logic                   clear,
   input  logic                   block_ready,
   output logic [AES_BLOCK_W-1:0] block_data,
   output logic                   block_valid,
   output logic [3:0]             byte_cnt,
   output logic                   overflow,
   output logic                   timeout_evt,
   output logic [7:0]             block_xor
);

   state_e                 state_q, state_d;
   logic [AES_BLOCK_W-1:0] data_q, data_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic                   evt_q, evt_d;
   logic                   accept;
   logic                   idle_inc;
   logic                   idle_clr;
   logic                   expire;

   // A byte is taken when not clearing and storage is free (collecting, or
   // the held block is leaving this very cycle).
   assign accept   = !clear && in_valid && ((state_q == COLLECT) || block_ready);
   assign idle_inc = !clear && !in_valid && (state_q == COLLECT) && (cnt_q != 4'd0);
   assign idle_clr = clear || accept;

   aes_idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_idle_timer (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (idle_clr),
      .inc_i    (idle_inc),
      .expire_o (expire)
   );

   // FSM next state, lane writes, overflow and timeout handling.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      evt_d   = 1'b0;
      if (clear) begin
         state_d = COLLECT;
         cnt_d   = 4'd0;
      end else begin
         unique case (state_q)
            COLLECT: begin
               if (expire) begin
                  cnt_d = 4'd0;
                  evt_d = 1'b1;
               end
            end
            HOLD: begin
               if (block_ready) begin
                  state_d = COLLECT;
               end else if (in_valid) begin
                  ovf_d = 1'b1;
               end
            end
            default: state_d = COLLECT;
         endcase
         if (accept) begin
            data_d = lane_write(data_q, cnt_q, in_data);
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'(AES_BLOCK_BYTES - 1)) begin
               state_d = HOLD;
            end
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
         state_q <= COLLECT;
         data_q  <= '0;
         cnt_q   <= 4'd0;
         ovf_q   <= 1'b0;
         evt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         evt_q   <= evt_d;
      end
   end

   assign block_data  = data_q;
   assign block_valid = (state_q == HOLD);
   assign byte_cnt    = cnt_q;
   assign overflow    = ovf_q;
   assign timeout_evt = evt_q;

`ifdef AES_COLLECT_CHECKSUM_EN
   logic [7:0] xacc_q, xacc_d;
   logic [7:0] bxor_q, bxor_d;

   // Running XOR restarts on each block's first byte; loaded into block_xor on the 16th.
   always_comb begin
      xacc_d = xacc_q;
      bxor_d = bxor_q;
      if (clear) begin
         xacc_d = 8'h00;
         bxor_d = 8'h00;
      end else if (expire) begin
         xacc_d = 8'h00;
      end else if (accept) begin
         xacc_d = (cnt_q == 4'd0) ? in_data : (xacc_q ^ in_data);
         if (cnt_q == 4'(AES_BLOCK_BYTES - 1)) begin
            bxor_d = xacc_q ^ in_data;
         end
      end
   end

   // Checksum registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xacc_q <= 8'h00;
         bxor_q <= 8'h00;
      end else begin
         xacc_q <= xacc_d;
         bxor_q <= bxor_d;
      end
   end

   assign block_xor = bxor_q;
`else
   assign block_xor = 8'h00;
`endif

endmodule
